pc_fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the 16-bit single-cycle CPU core. It owns the program counter and issues requests to a synchronous instruction memory with 1-cycle read latency. Fetched words are buffered in a 2-entry queue with their PCs and handed to the core over a valid/ready handshake. It also supports branch/jump redirect and halt.

---
 rtl/pc_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: owns the PC, reads a 1-cycle-latency instruction memory and queues words with their PCs.
// Latency: a request in cycle C shows up as inst_valid in cycle C+2; first valid in the 4th cycle after reset.
// Backpressure: inst_ready=0 lets the 2-entry buffer fill; fetch stalls while buffer plus in-flight word reach DEPTH.
// Optional FETCH_STATS_EN adds saturating fetch_count / redirect_count outputs.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'd9,
    parameter logic [15:0] PC_STEP  = 16'd2,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst_data,
    output logic [15:0] inst_pc,
    output logic [15:0] pc_next,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        halted
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] redirect_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc;
    logic [15:0] tag;
    logic        inflight;
    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic        issue;
    logic        room;
    logic        push;
    logic        pop;
    logic [15:0] buf_data [2];
    logic [15:0] buf_pc   [2];

    // Space check counts the word already in flight; a same-cycle pop does not free a slot.
    assign room = (count + {1'b0, inflight}) < 2'(DEPTH);
    // A response is kept unless a redirect in its arrival cycle throws it away.
    assign push = inflight && !redirect_valid;
    assign pop  = inst_valid && inst_ready;
    assign tail = head ^ count[0];

    // Next-state and issue decision; redirect beats halt, and halt is ignored once halted.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH: begin
                issue = room && !halt && !redirect_valid;
                if (halt && !redirect_valid)
                    state_nxt = HALTED;
            end
            HALTED: begin
                if (redirect_valid)
                    state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // PC, in-flight tracking and buffer occupancy; redirect flushes everything queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            tag      <= 16'd0;
            inflight <= 1'b0;
            count    <= 2'd0;
            head     <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue)
                tag <= pc;
            if (redirect_valid) begin
                pc    <= redirect_pc;
                count <= 2'd0;
            end else begin
                if (issue)
                    pc <= pc + PC_STEP;
                if (pop)
                    head <= ~head;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Buffer storage: the returning word is written at the tail together with its PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_data[0] <= 16'd0;
            buf_data[1] <= 16'd0;
            buf_pc[0]   <= 16'd0;
            buf_pc[1]   <= 16'd0;
        end else if (push) begin
            buf_data[tail] <= imem_rdata;
            buf_pc[tail]   <= tag;
        end
    end

    assign imem_req   = issue;
    assign imem_addr  = pc;
    assign inst_valid = (count != 2'd0);
    assign inst_data  = inst_valid ? buf_data[head] : 16'd0;
    assign inst_pc    = inst_valid ? buf_pc[head]   : 16'd0;
    assign pc_next    = inst_pc + PC_STEP;
    assign halted     = (state == HALTED);

`ifdef FETCH_STATS_EN
    // Saturating counters of accepted fetch words and redirect cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count    <= 16'd0;
            redirect_count <= 16'd0;
        end else begin
            if (push && fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;
            if (redirect_valid && redirect_count != 16'hFFFF)
                redirect_count <= redirect_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random traffic against a queue-based model.
// Memory model returns addr ^ 16'hA5A5 one cycle after each request, garbage otherwise.
// Every cycle all outputs are compared with the model; directed points add fixed expectations.
module tb_pc_fetch_unit;

    localparam int S_IDLE = 0, S_FETCH = 1, S_HALTED = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic [15:0] pc_next;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [15:0] fetch_count;
    logic [15:0] redirect_count;
`endif

    pc_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    always @(posedge clk)
        imem_rdata <= imem_req ? mem_f(imem_addr) : 16'($urandom);

    // Reference model state
    int          m_state;
    logic [15:0] m_pc;
    logic [15:0] m_tag;
    bit          m_inflight;
    logic [15:0] q_pc  [$];
    logic [15:0] q_dat [$];
    logic [15:0] m_fc, m_rc;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_req  = 0;
    logic [15:0] delivered [$];
    logic [15:0] nxt_at_fffe;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        m_state    = S_IDLE;
        m_pc       = 16'd9;
        m_tag      = 16'd0;
        m_inflight = 0;
        q_pc.delete();
        q_dat.delete();
        m_fc = 16'd0;
        m_rc = 16'd0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare, then advance the model.
    task automatic step(input bit rdy, input bit hlt, input bit rv, input logic [15:0] rpc, input bit rst);
        bit          e_vld, e_req, pop, push;
        logic [15:0] e_pc, e_dat;
        @(negedge clk);
        reset          = rst;
        inst_ready     = rdy;
        halt           = hlt;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        e_vld = (q_pc.size() > 0);
        e_pc  = e_vld ? q_pc[0]  : 16'd0;
        e_dat = e_vld ? q_dat[0] : 16'd0;
        e_req = (m_state == S_FETCH) && (q_pc.size() + int'(m_inflight) < 2) && !hlt && !rv;
        chk("imem_req",   16'(imem_req),   16'(e_req));
        chk("imem_addr",  imem_addr,       m_pc);
        chk("inst_valid", 16'(inst_valid), 16'(e_vld));
        chk("inst_data",  inst_data,       e_dat);
        chk("inst_pc",    inst_pc,         e_pc);
        chk("pc_next",    pc_next,         e_pc + 16'd2);
        chk("halted",     16'(halted),     16'(m_state == S_HALTED));
`ifdef FETCH_STATS_EN
        chk("fetch_count",    fetch_count,    m_fc);
        chk("redirect_count", redirect_count, m_rc);
`endif
        if (imem_req) n_req++;
        if (inst_valid && inst_ready) delivered.push_back(inst_pc);
        if (inst_valid && inst_pc == 16'hFFFE) nxt_at_fffe = pc_next;

        if (rst) begin
            reset_model();
        end else begin
            pop  = e_vld && rdy;
            push = m_inflight && !rv;
            if (push && m_fc != 16'hFFFF) m_fc++;
            if (rv && m_rc != 16'hFFFF) m_rc++;
            if (rv) begin
                q_pc.delete();
                q_dat.delete();
                m_pc = rpc;
            end else begin
                if (pop) begin
                    void'(q_pc.pop_front());
                    void'(q_dat.pop_front());
                end
                if (push) begin
                    q_pc.push_back(m_tag);
                    q_dat.push_back(mem_f(m_tag));
                end
            end
            m_inflight = e_req;
            if (e_req) begin
                m_tag = m_pc;
                m_pc  = m_pc + 16'd2;
            end
            case (m_state)
                S_IDLE:   m_state = S_FETCH;
                S_FETCH:  if (hlt && !rv) m_state = S_HALTED;
                default:  if (rv) m_state = S_FETCH;
            endcase
        end
    endtask

    task automatic chk_dlv(input string tag, input int idx, input logic [15:0] exp);
        chk({tag, "_count"}, 16'(delivered.size() > idx), 16'd1);
        if (delivered.size() > idx) chk(tag, delivered[idx], exp);
    endtask

    initial begin
        reset = 1'b1; inst_ready = 1'b0; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'd0;
        repeat (2) @(posedge clk);
        reset_model();

        // Reset state
        step(1, 0, 0, 16'd0, 1);
        step(1, 0, 0, 16'd0, 1);
        chk("rst_req",  16'(imem_req),   16'd0);
        chk("rst_addr", imem_addr,       16'd9);
        chk("rst_vld",  16'(inst_valid), 16'd0);
        chk("rst_pcn",  pc_next,         16'd2);
        chk("rst_hlt",  16'(halted),     16'd0);

        // First fetch latency and in-order stream
        delivered.delete();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 16'd0, 0);
            chk("early_vld", 16'(inst_valid), 16'd0);
        end
        step(1, 0, 0, 16'd0, 0);
        chk("first_vld",  16'(inst_valid), 16'd1);
        chk("first_pc",   inst_pc,         16'd9);
        chk("first_data", inst_data,       16'hA5AC);
        chk("first_pcn",  pc_next,         16'd11);
        repeat (8) step(1, 0, 0, 16'd0, 0);
        chk_dlv("stream0", 0, 16'd9);
        chk_dlv("stream1", 1, 16'd11);
        chk_dlv("stream2", 2, 16'd13);
        chk_dlv("stream3", 3, 16'd15);

        // Backpressure: buffer fills with exactly two requests
        step(0, 0, 0, 16'd0, 1);
        n_req = 0;
        repeat (6) step(0, 0, 0, 16'd0, 0);
        chk("bp_nreq", 16'(n_req),       16'd2);
        chk("bp_vld",  16'(inst_valid),  16'd1);
        chk("bp_head", inst_pc,          16'd9);
        chk("bp_req",  16'(imem_req),    16'd0);
        delivered.delete();
        repeat (6) step(1, 0, 0, 16'd0, 0);
        chk_dlv("bp_out0", 0, 16'd9);
        chk_dlv("bp_out1", 1, 16'd11);
        chk_dlv("bp_out2", 2, 16'd13);

        // Redirect with one buffered word and one in flight
        step(1, 0, 0, 16'd0, 1);
        repeat (3) step(1, 0, 0, 16'd0, 0);
        step(1, 0, 1, 16'h0040, 0);
        chk("rd_head", inst_pc, 16'd9);
        delivered.delete();
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 16'd0, 0);
            chk("rd_gap", 16'(inst_valid), 16'd0);
        end
        repeat (6) step(1, 0, 0, 16'd0, 0);
        chk_dlv("rd_out0", 0, 16'h0040);
        chk_dlv("rd_out1", 1, 16'h0042);

        // PC wrap
        nxt_at_fffe = 16'h1111;
        step(1, 0, 1, 16'hFFFE, 0);
        delivered.delete();
        repeat (8) step(1, 0, 0, 16'd0, 0);
        chk_dlv("wrap0", 0, 16'hFFFE);
        chk_dlv("wrap1", 1, 16'h0000);
        chk("wrap_pcn", nxt_at_fffe, 16'h0000);

        // Halt, drain, restart via redirect
        step(1, 1, 0, 16'd0, 0);
        chk("halt_req", 16'(imem_req), 16'd0);
        n_req = 0;
        step(1, 1, 0, 16'd0, 0);
        chk("halt_flag", 16'(halted), 16'd1);
        repeat (4) step(1, 1, 0, 16'd0, 0);
        chk("halt_nreq",  16'(n_req),      16'd0);
        chk("halt_drain", 16'(inst_valid), 16'd0);
        step(1, 0, 1, 16'h0020, 0);
        delivered.delete();
        repeat (6) step(1, 0, 0, 16'd0, 0);
        chk("resume_hlt", 16'(halted), 16'd0);
        chk_dlv("resume0", 0, 16'h0020);

        // Reset mid-stream with a full buffer
        repeat (5) step(0, 0, 0, 16'd0, 0);
        chk("full_vld", 16'(inst_valid), 16'd1);
        step(0, 0, 0, 16'd0, 1);
        step(1, 0, 0, 16'd0, 0);
        chk("mrst_vld",  16'(inst_valid), 16'd0);
        chk("mrst_req",  16'(imem_req),   16'd0);
        chk("mrst_addr", imem_addr,       16'd9);
`ifdef FETCH_STATS_EN
        chk("mrst_fc", fetch_count,    16'd0);
        chk("mrst_rc", redirect_count, 16'd0);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 11) == 0,
                 16'($urandom),
                 $urandom_range(0, 149) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
